// File: rtl/shr_seq.sv
// Sequential 16-bit right shifter: one bit per clock, up to 15 positions,
// in logical, arithmetic or rotate mode, with a start/busy/done handshake.
module shr_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  amt,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 4;

    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    w_q, w_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [1:0]      m_q, m_d;
    logic [W-1:0]    out_q, out_d;
    logic            fill;
    logic [W-1:0]    w_shift;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            out_q   <= out_d;
        end
    end

    // One-position right shift of the working register; mode 11 falls to zero fill
    always_comb begin
        case (m_q)
            MODE_SRA: fill = w_q[W-1];
            MODE_ROR: fill = w_q[0];
            default:  fill = 1'b0;
        endcase
        w_shift = {fill, w_q[W-1:1]};
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d   = in;
                    cnt_d = amt;
                    m_d   = mode;
                    if (amt == AW'(0)) begin
                        state_d = DONE;
                        out_d   = in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_d   = w_shift;
                cnt_d = AW'(cnt_q - AW'(1));
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                    out_d   = w_shift;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        out  = out_q;
    end

endmodule

// File: tb/tb_shr_seq.sv
// Directed self-checking bench for shr_seq: latency, busy width, result,
// start-while-busy rejection, output hold and asynchronous reset abort.
module tb_shr_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_s;
    logic [3:0]  amt_s;
    logic [1:0]  mode_s;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int checks   = 0;
    int failures = 0;

    shr_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_s),
        .amt   (amt_s),
        .mode  (mode_s),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it until busy drops (bounded)
    task automatic run_op(input string tag, input logic [15:0] i, input logic [3:0] a,
                          input logic [1:0] md, input logic [15:0] exp, input bit disturb);
        int busy_n;
        int done_n;
        int done_k;
        logic [15:0] out_at_done;
        @(negedge clk);
        in_s = i; amt_s = a; mode_s = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = 0; done_n = 0; done_k = -1; out_at_done = 16'h0;
        for (int k = 0; k < 24 && busy; k++) begin
            busy_n++;
            if (done) begin
                done_n++;
                done_k = k;
                out_at_done = out;
            end
            if (disturb) begin
                start = 1'b1; in_s = 16'hFFFF; amt_s = 4'hF; mode_s = 2'b10;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_busy_drop"}, 16'(busy), 16'h0);
        chk({tag, "_done_cycle"}, 16'(done_k), 16'(a));
        chk({tag, "_busy_cycles"}, 16'(busy_n), 16'(a) + 16'h1);
        chk({tag, "_done_count"}, 16'(done_n), 16'h1);
        chk({tag, "_out"}, out_at_done, exp);
        @(posedge clk); #1;
        chk({tag, "_out_hold"}, out, exp);
        chk({tag, "_idle_after"}, 16'(busy), 16'h0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; in_s = 16'h0; amt_s = 4'h0; mode_s = 2'b00;
        #12;
        chk("reset_out", out, 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_done", 16'(done), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("srl_1",      16'h8001, 4'd1,  2'b00, 16'h4000, 1'b0);
        run_op("sra_15_neg", 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0);
        run_op("sra_15_pos", 16'h7FFF, 4'd15, 2'b01, 16'h0000, 1'b0);
        run_op("ror_4_a",    16'h0001, 4'd4,  2'b10, 16'h1000, 1'b0);
        run_op("ror_4_b",    16'hF00F, 4'd4,  2'b10, 16'hFF00, 1'b0);
        run_op("mode11_4",   16'hF00F, 4'd4,  2'b11, 16'h0F00, 1'b0);
        run_op("zero_amt",   16'hBEEF, 4'd0,  2'b01, 16'hBEEF, 1'b0);
        run_op("disturbed",  16'h1234, 4'd3,  2'b00, 16'h0246, 1'b1);

        // Abort an amt=10 shift with an asynchronous reset between edges
        @(negedge clk);
        in_s = 16'hFFFF; amt_s = 4'd10; mode_s = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_out", out, 16'h0000);
        chk("rst_mid_busy", 16'(busy), 16'h0);
        chk("rst_mid_done", 16'(done), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("rst_no_late_done", 16'(seen), 16'h0);
        chk("rst_out_kept_zero", out, 16'h0000);

        run_op("after_rst", 16'hA5A5, 4'd2, 2'b01, 16'hE969, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
